// File: rtl/cnn_seq_pkg.sv
// Shared types for the CNN stage sequencer: FSM state encoding and the stage-index width helper.
package cnn_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_PAUSE,
        S_DONE,
        S_ERROR
    } seq_state_e;

    // A single-stage chain still needs a 1-bit index register.
    function automatic int unsigned STAGE_IDX_W(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cnn_stage_sequencer_next_sel.sv
// Priority encoder: lowest set bit of en_q strictly above idx, or from bit 0 when first is set.
module stage_next_sel #(
    parameter int unsigned N  = 5,
    parameter int unsigned IW = 3
) (
    input  logic [N-1:0]  en_q,
    input  logic [IW-1:0] idx,
    input  logic          first,
    output logic [IW-1:0] next_idx,
    output logic          none
);

    logic w_found;

    always_comb begin
        w_found  = 1'b0;
        next_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!w_found && en_q[i] && (first || (IW'(i) > idx))) begin
                next_idx = IW'(i);
                w_found  = 1'b1;
            end
        end
        none = !w_found;
    end

endmodule

// File: rtl/cnn_stage_sequencer.sv
// Configurable start/done chain for the CNN pipeline stages, with bypass mask, single-step,
// per-stage watchdog and a saturating run-length counter.
module cnn_stage_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES     = 5,
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  go,
    input  logic                                  extra,
    input  logic                                  step,
    input  logic [NUM_STAGES-1:0]                 stage_en,
    input  logic [NUM_STAGES-1:0]                 stage_done,
    output logic [NUM_STAGES-1:0]                 stage_start,
    output logic [NUM_STAGES-1:0]                 stage_active,
    output logic                                  done,
    output logic                                  error,
    output logic [STAGE_IDX_W(NUM_STAGES)-1:0]    err_stage,
    output logic [CNT_W-1:0]                      run_cycles
);

    localparam int unsigned IW   = STAGE_IDX_W(NUM_STAGES);
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    seq_state_e              r_state, w_state_nxt;
    logic [IW-1:0]           r_idx, w_idx_nxt;
    logic [IW-1:0]           r_err_stage, w_err_nxt;
    logic [NUM_STAGES-1:0]   r_en_q, w_en_nxt;
    logic [WD_W-1:0]         r_wdog, w_wdog_nxt;
    logic [CNT_W-1:0]        r_run_cycles, w_cyc_nxt, w_cyc_inc;
    logic [NUM_STAGES-1:0]   w_sel_en, w_onehot;
    logic [IW-1:0]           w_next_idx;
    logic                    w_sel_first, w_none;

    // In IDLE the mask is not yet latched, so the first search looks at the live input.
    assign w_sel_first = (r_state == S_IDLE);
    assign w_sel_en    = w_sel_first ? stage_en : r_en_q;
    assign w_cyc_inc   = (&r_run_cycles) ? r_run_cycles : r_run_cycles + CNT_W'(1);

    stage_next_sel #(
        .N  (NUM_STAGES),
        .IW (IW)
    ) u_next_sel (
        .en_q     (w_sel_en),
        .idx      (r_idx),
        .first    (w_sel_first),
        .next_idx (w_next_idx),
        .none     (w_none)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_err_nxt   = r_err_stage;
        w_en_nxt    = r_en_q;
        w_wdog_nxt  = r_wdog;
        w_cyc_nxt   = r_run_cycles;
        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_en_nxt  = stage_en;
                    w_cyc_nxt = '0;
                    if (w_none) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt   = w_next_idx;
                        w_state_nxt = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                w_wdog_nxt  = '0;
                w_cyc_nxt   = w_cyc_inc;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_cyc_nxt = w_cyc_inc;
                if (stage_done[r_idx]) begin
                    if (w_none) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt   = w_next_idx;
                        w_state_nxt = extra ? S_PAUSE : S_LAUNCH;
                    end
                end else if (r_wdog == WD_LAST) begin
                    w_err_nxt   = r_idx;
                    w_state_nxt = S_ERROR;
                end else begin
                    w_wdog_nxt = r_wdog + WD_W'(1);
                end
            end
            S_PAUSE: begin
                w_cyc_nxt = w_cyc_inc;
                if (step || !extra) begin
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_DONE: begin
                if (!go) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ERROR: begin
                w_state_nxt = S_ERROR;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_err_stage  <= '0;
            r_en_q       <= '0;
            r_wdog       <= '0;
            r_run_cycles <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_err_stage  <= w_err_nxt;
            r_en_q       <= w_en_nxt;
            r_wdog       <= w_wdog_nxt;
            r_run_cycles <= w_cyc_nxt;
        end
    end

    assign w_onehot     = NUM_STAGES'(1) << r_idx;
    assign stage_start  = (r_state == S_LAUNCH) ? w_onehot : '0;
    assign stage_active = ((r_state == S_LAUNCH) || (r_state == S_WAIT)) ? w_onehot : '0;
    assign done         = (r_state == S_DONE);
    assign error        = (r_state == S_ERROR);
    assign err_stage    = r_err_stage;
    assign run_cycles   = r_run_cycles;

endmodule
